div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 integer divider in the EX stage. It consumes the forwarded operands that the operand-bypass mux produces for DIV/DIVU instructions and returns quotient (LO) and remainder (HI) after a fixed multi-cycle latency. While it works, it holds the pipeline through a stall request. EX sees it as a single start/done handshake.

## Interface
Parameters:
- WIDTH, 32, operand and result width
- ITERS, WIDTH, restoring iterations; fixed equal to WIDTH

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  synchronous, active-low reset
- div_valid  in  1  EX holds a DIV/DIVU with bypassed operands; held high until div_done
- div_signed  in  1  1 = DIV (two's complement), 0 = DIVU
- div_src1  in  WIDTH  dividend (bypassed rs value)
- div_src2  in  WIDTH  divisor (bypassed rt value)
- flush  in  1  exception/ERET flush of EX; aborts the operation in flight
- quotient  out  WIDTH  registered result to LO
- remainder  out  WIDTH  registered result to HI
- div_busy  out  1  state != IDLE
- div_done  out  1  one-cycle pulse; quotient/remainder valid
- stall_req  out  1  combinational div_valid & ~div_done, to the hazard/stall logic

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE → ITER when div_valid & ~flush.
  - Latch the absolute values of the operands. Absolute value is taken only when div_signed.
  - Latch sign_q = s1 ^ s2 and sign_r = s1, where s1/s2 are the operand MSBs when div_signed, else 0.
  - Latch div0 = (div_src2 == 0) and the raw div_src1. Clear the iteration counter.
- ITER: one restoring step per cycle on a 2·WIDTH partial-remainder register.
  - Shift left by 1.
  - Trial subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and set quotient bit 1; else restore and set 0.
  - Counter is 0..ITERS-1. After step ITERS-1, go to FIX.
- FIX: sign correction.
  - Negate the quotient if sign_q; negate the remainder if sign_r.
  - If div0, override: quotient = all ones, remainder = raw dividend (both modes, no sign fix).
  - Write quotient/remainder. Go to DONE.
- DONE: div_done = 1 for this cycle only. Go to IDLE.
- Results hold their value until the next FIX write. They are not cleared on IDLE or flush.
- Operands are sampled only on acceptance. Input changes during ITER/FIX/DONE are ignored.
- Signed overflow (0x80000000 / 0xFFFFFFFF): natural result, quotient 0x80000000, remainder 0. No trap.
- flush in any state: next state IDLE, no div_done, results unchanged. flush takes priority over acceptance in IDLE.
- resetn low (sampled on a clock edge, any state): state IDLE, counter 0, quotient 0, remainder 0, div_busy 0, div_done 0.

## Timing
- Accept at edge ending cycle T (IDLE & div_valid).
- ITER occupies T+1..T+32, FIX is T+33, DONE (div_done = 1) is T+34. Fixed latency is 34 cycles, independent of the operand values.
- div_busy is high T+1..T+34.
- stall_req is high from T until T+33 inclusive, and low at T+34. EX advances on the div_done cycle.
- Back-to-back: if div_valid is still high in the IDLE cycle T+35 (the next divide is in EX), it is accepted at T+35. There is no bubble other than the IDLE cycle.
- div_valid dropping mid-operation (without flush) does not abort. The result completes and div_done still pulses.

## Structure
- Shared package div_pkg holds:
  - the state enum (IDLE/ITER/FIX/DONE)
  - DIV_WIDTH = 32
  - DIV_ITERS = 32
  - DIV_CNT_W = 5
- Sub-module div_abs_neg (WIDTH; in, neg_en → out = neg_en ? -in : in). It is instantiated for operand magnitude (×2) and result sign fix (×2).
- The FSM, counter and partial-remainder datapath stay in div_unit.

## Test plan
- DIVU 100 / 7 → quotient 14, remainder 2. div_done exactly at T+34. stall_req high T..T+33.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). DIVU on the same operands → quotient 0x7FFFFFFC, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIV 5 / 0 → quotient 0xFFFFFFFF, remainder 5.
- Flush at T+10 → div_busy 0 at T+11, no div_done, quotient/remainder keep their prior values. A new div_valid at T+11 is accepted and completes at T+45.
- Hold div_valid high across two divides (12/5 then 9/3) → done pulses at T+34 and T+69 with results 2/2 then 3/0.
- resetn low at T+20 for one cycle → every output 0 on the next cycle, state IDLE, no div_done.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   DIV_WIDTH   default operand/result width
//   DIV_ITERS   restoring iterations (one quotient bit per cycle)
//   DIV_CNT_W   width of the iteration counter
//   div_state_e sequencing states of div_unit
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_if.sv
// EX-stage <-> divider handshake bundle.
//   master (EX side):  drives div_valid, div_signed, div_src1, div_src2, flush
//                      receives quotient, remainder, div_busy, div_done, stall_req
//   slave  (divider):  the mirror image
interface div_if #(
    parameter int WIDTH = 32
);
    logic             div_valid;
    logic             div_signed;
    logic [WIDTH-1:0] div_src1;
    logic [WIDTH-1:0] div_src2;
    logic             flush;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_busy;
    logic             div_done;
    logic             stall_req;

    modport master (
        output div_valid, div_signed, div_src1, div_src2, flush,
        input  quotient, remainder, div_busy, div_done, stall_req
    );

    modport slave (
        input  div_valid, div_signed, div_src1, div_src2, flush,
        output quotient, remainder, div_busy, div_done, stall_req
    );
endinterface

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negation.
//   i_val     operand
//   i_neg_en  1 = output -i_val, 0 = pass through
//   o_val     result
// Used both to take operand magnitudes and to re-apply result signs.
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg_en,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg_en ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
//   clk      rising-edge clock
//   resetn   synchronous active-low reset
//   div_bus  div_if.slave: start/done handshake, operands, flush,
//            registered quotient (LO) / remainder (HI), busy and stall request
// Fixed latency: accept in cycle T, div_done in cycle T+34 (WIDTH = 32).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for div_valid; operands captured on acceptance
// ITER  | one restoring step per cycle, counter 0..ITERS-1
// FIX   | apply result signs / divide-by-zero override, write results
// DONE  | div_done pulse for one cycle, then back to IDLE
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic clk,
    input  logic resetn,
    div_if.slave div_bus
);

    localparam int CNT_W = (ITERS == DIV_ITERS) ? DIV_CNT_W : $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    div_state_e         r_state;
    div_state_e         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_rem;        // {partial remainder, dividend/quotient bits}
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_dividend_raw;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;

    logic               w_s1;
    logic               w_s2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_upper;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0]   w_q_fixed;
    logic [WIDTH-1:0]   w_r_fixed;
    logic               w_accept;
    logic               w_done;

    assign w_s1 = div_bus.div_signed & div_bus.div_src1[WIDTH-1];
    assign w_s2 = div_bus.div_signed & div_bus.div_src2[WIDTH-1];

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_src1 (
        .i_val    (div_bus.div_src1),
        .i_neg_en (w_s1),
        .o_val    (w_abs1)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_src2 (
        .i_val    (div_bus.div_src2),
        .i_neg_en (w_s2),
        .o_val    (w_abs2)
    );

    // Upper WIDTH+1 bits of the remainder register after a left shift by one.
    // The partial remainder is always below the divisor, so the shifted value
    // is below twice the divisor and the borrow bit of w_diff alone tells
    // whether the trial subtraction went negative.
    assign w_upper    = r_rem[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_upper - {1'b0, r_divisor};
    assign w_rem_next = {(w_diff[WIDTH] ? w_upper[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                         r_rem[WIDTH-2:0], ~w_diff[WIDTH]};

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_quot (
        .i_val    (r_rem[WIDTH-1:0]),
        .i_neg_en (r_sign_q),
        .o_val    (w_q_fixed)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .i_val    (r_rem[2*WIDTH-1:WIDTH]),
        .i_neg_en (r_sign_r),
        .o_val    (w_r_fixed)
    );

    assign w_accept = (r_state == IDLE) & div_bus.div_valid & ~div_bus.flush;
    assign w_done   = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (div_bus.flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (div_bus.div_valid) w_next_state = ITER;
                ITER:    if (r_cnt == LAST_CNT) w_next_state = FIX;
                FIX:     w_next_state = DONE;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt          <= '0;
            r_rem          <= '0;
            r_divisor      <= '0;
            r_dividend_raw <= '0;
            r_sign_q       <= 1'b0;
            r_sign_r       <= 1'b0;
            r_div0         <= 1'b0;
            r_quotient     <= '0;
            r_remainder    <= '0;
        end else begin
            if (w_accept) begin
                r_rem          <= {{WIDTH{1'b0}}, w_abs1};
                r_divisor      <= w_abs2;
                r_dividend_raw <= div_bus.div_src1;
                r_sign_q       <= w_s1 ^ w_s2;
                r_sign_r       <= w_s1;
                r_div0         <= (div_bus.div_src2 == '0);
                r_cnt          <= '0;
            end else if ((r_state == ITER) && !div_bus.flush) begin
                r_rem <= w_rem_next;
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Results persist until the next completed divide; a flush in FIX
            // leaves the previous values in place.
            if ((r_state == FIX) && !div_bus.flush) begin
                if (r_div0) begin
                    r_quotient  <= '1;
                    r_remainder <= r_dividend_raw;
                end else begin
                    r_quotient  <= w_q_fixed;
                    r_remainder <= w_r_fixed;
                end
            end
        end
    end

    assign div_bus.quotient  = r_quotient;
    assign div_bus.remainder = r_remainder;
    assign div_bus.div_busy  = (r_state != IDLE);
    assign div_bus.div_done  = w_done;
    assign div_bus.stall_req = div_bus.div_valid & ~w_done;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    exp_t sb_q[$];

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .div_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, with the
    // architectural divide-by-zero result.
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint na, nb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            return;
        end
        if (sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = 32'(na / nb);
        r = 32'(na % nb);
    endfunction

    // Monitor: every div_done pops one expectation.
    always @(negedge clk) begin
        if (resetn && bus.div_done) begin
            exp_t e;
            done_count++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 cycle=%0d", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("quotient", bus.quotient, e.q);
                chk("remainder", bus.remainder, e.r);
                chk("done_cycle", 32'(cyc), 32'(e.due));
                last_q = e.q;
                last_r = e.r;
            end
        end
    end

    // Issue one divide in the current (idle) cycle T; returns in cycle T+35.
    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit keep);
        int          t;
        int          prev;
        bit          got;
        logic [31:0] eq, er;
        bus.div_valid  = 1'b1;
        bus.div_signed = sgn;
        bus.div_src1   = a;
        bus.div_src2   = b;
        t = cyc;
        ref_div(sgn, a, b, eq, er);
        sb_q.push_back('{q: eq, r: er, due: t + 34});
        #1;
        chk("stall_at_T", 32'(bus.stall_req), 32'd1);
        prev = done_count;
        got  = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            // operands changing mid-flight must be ignored
            bus.div_src1   = $urandom;
            bus.div_src2   = $urandom;
            bus.div_signed = 1'($urandom);
            if (cyc == t + 33) chk("stall_at_T33", 32'(bus.stall_req), 32'd1);
            if (done_count != prev) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none expected=cycle_%0d", t + 34);
            void'(sb_q.pop_front());
        end else begin
            chk("stall_at_done", 32'(bus.stall_req), 32'd0);
        end
        if (!keep) bus.div_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, b;
        int          t;
        bus.div_valid  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_src1   = '0;
        bus.div_src2   = '0;
        bus.flush      = 1'b0;

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        chk("rst_busy", 32'(bus.div_busy), 32'd0);
        chk("rst_done", 32'(bus.div_done), 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);

        run_op(1'b0, 32'd100, 32'd7, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b1, 32'd5, 32'd0, 1'b0);
        run_op(1'b0, 32'd5, 32'd0, 1'b0);

        // flush at T+10: no done, results untouched, immediate restart
        bus.div_valid  = 1'b1;
        bus.div_signed = 1'b0;
        bus.div_src1   = 32'd1000;
        bus.div_src2   = 32'd3;
        repeat (10) @(negedge clk);
        bus.flush     = 1'b1;
        bus.div_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("flush_busy", 32'(bus.div_busy), 32'd0);
        chk("flush_quotient", bus.quotient, last_q);
        chk("flush_remainder", bus.remainder, last_r);
        chk("flush_done", 32'(bus.div_done), 32'd0);
        run_op(1'b0, 32'd77, 32'd5, 1'b0);

        // back-to-back with div_valid held high
        run_op(1'b0, 32'd12, 32'd5, 1'b1);
        run_op(1'b0, 32'd9, 32'd3, 1'b0);

        // reset mid-operation at T+20
        bus.div_valid  = 1'b1;
        bus.div_signed = 1'b1;
        bus.div_src1   = 32'd4321;
        bus.div_src2   = 32'd17;
        t = cyc;
        while (cyc < t + 20) @(negedge clk);
        resetn        = 1'b0;
        bus.div_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst2_quotient", bus.quotient, 32'd0);
        chk("rst2_remainder", bus.remainder, 32'd0);
        chk("rst2_busy", 32'(bus.div_busy), 32'd0);
        chk("rst2_done", 32'(bus.div_done), 32'd0);
        chk("rst2_stall", 32'(bus.stall_req), 32'd0);
        last_q = '0;
        last_r = '0;
        repeat (40) @(negedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       b = 32'hFFFF_FFFF;
                4:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op(1'($urandom), a, b, 1'($urandom));
        end
        bus.div_valid = 1'b0;
        repeat (40) @(negedge clk);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
